// File: rtl/nmea_uart_rx.sv
// 8N1 UART receiver for an NMEA GPS byte stream, writing each good byte into a downstream FIFO.
// Mid-bit sampling with a glitch-rejecting start check, and break handling after a framing error.
module nmea_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    input  logic       i_full,
    output logic       o_write,
    output logic [7:0] o_char,
    output logic       o_frame_err,
    output logic       o_overrun
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    localparam logic [12:0] HalfCnt = 13'(CLKS_PER_BIT / 2 - 1);
    localparam logic [12:0] FullCnt = 13'(CLKS_PER_BIT - 1);

    logic        rx_meta_q;
    logic        rx_s_q;
    state_e      state_q;
    logic [12:0] cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic        write_q;
    logic [7:0]  char_q;
    logic        frame_err_q;
    logic        overrun_q;

    // Both sync flops reset to the idle line level so a reset can't fake a start bit.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= StIdle;
            cnt_q       <= 13'd0;
            idx_q       <= 3'd0;
            shift_q     <= 8'd0;
            write_q     <= 1'b0;
            char_q      <= 8'd0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            write_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!rx_s_q) begin
                        state_q <= StStart;
                        cnt_q   <= 13'd0;
                    end
                end
                StStart: begin
                    if (cnt_q == HalfCnt) begin
                        cnt_q <= 13'd0;
                        if (!rx_s_q) begin
                            state_q <= StData;
                            idx_q   <= 3'd0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + 13'd1;
                    end
                end
                StData: begin
                    if (cnt_q == FullCnt) begin
                        shift_q[idx_q] <= rx_s_q;
                        cnt_q          <= 13'd0;
                        idx_q          <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + 13'd1;
                    end
                end
                StStop: begin
                    if (cnt_q == FullCnt) begin
                        cnt_q <= 13'd0;
                        if (rx_s_q) begin
                            // i_full only matters here; a full FIFO drops the byte.
                            if (!i_full) begin
                                write_q <= 1'b1;
                                char_q  <= shift_q;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                            state_q <= StIdle;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= StBreak;
                        end
                    end else begin
                        cnt_q <= cnt_q + 13'd1;
                    end
                end
                StBreak: begin
                    if (rx_s_q) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= 13'd0;
                end
            endcase
        end
    end

    assign o_write     = write_q;
    assign o_char      = char_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_nmea_uart_rx.sv
// Directed bench for nmea_uart_rx at 16 clocks per bit.
// A negedge monitor logs pulses; each scenario task checks the deltas it expects.
module tb_nmea_uart_rx;

    localparam int unsigned Cpb = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       full;
    logic       write;
    logic [7:0] char_o;
    logic       frame_err;
    logic       overrun;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         fall_cyc = 0;
    int         wcnt = 0;
    int         fcnt = 0;
    int         ocnt = 0;
    int         excl_err = 0;
    int         long_err = 0;
    int         write_cyc = 0;
    logic       prev_pulse = 1'b0;
    logic [7:0] got_q[$];

    nmea_uart_rx #(.CLKS_PER_BIT(Cpb)) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_rx       (rx),
        .i_full     (full),
        .o_write    (write),
        .o_char     (char_o),
        .o_frame_err(frame_err),
        .o_overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (write) begin
            wcnt      <= wcnt + 1;
            write_cyc <= cyc;
            got_q.push_back(char_o);
        end
        if (frame_err) fcnt <= fcnt + 1;
        if (overrun) ocnt <= ocnt + 1;
        if ((32'(write) + 32'(frame_err) + 32'(overrun)) > 1) excl_err <= excl_err + 1;
        if (prev_pulse && (write || frame_err || overrun)) long_err <= long_err + 1;
        prev_pulse <= write | frame_err | overrun;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // full_mode: 0 never full, 1 full for the whole frame, 2 full only before the stop bit
    task automatic send_byte(input logic [7:0] b, input int full_mode, input int stop_low);
        full     = (full_mode != 0);
        rx       = 1'b0;
        fall_cyc = cyc;
        tick(Cpb);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(Cpb);
        end
        if (full_mode == 2) full = 1'b0;
        if (stop_low > 0) begin
            rx = 1'b0;
            tick(stop_low);
        end
        rx = 1'b1;
        tick(Cpb);
        full = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx    = 1'b1;
        full  = 1'b0;
        tick(3);
        checks++;
        if (write !== 1'b0) begin
            errors++;
            $display("FAIL reset_write: got %b want 0", write);
        end
        checks++;
        if (char_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_char: got %h want 00", char_o);
        end
        checks++;
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_errs: got fe=%b ov=%b want 0 0", frame_err, overrun);
        end
        rst_n = 1'b1;
        tick(10);
        checks++;
        if (wcnt !== 0 || fcnt !== 0 || ocnt !== 0) begin
            errors++;
            $display("FAIL reset_idle: got w=%0d f=%0d o=%0d want 0 0 0", wcnt, fcnt, ocnt);
        end
    endtask

    task automatic test_single;
        int w0 = wcnt;
        int f0 = fcnt;
        int o0 = ocnt;
        int q0 = got_q.size();
        int lat;
        send_byte(8'h24, 0, 0);
        tick(4);
        checks++;
        if (wcnt - w0 !== 1) begin
            errors++;
            $display("FAIL single_count: got %0d writes want 1", wcnt - w0);
        end
        checks++;
        if (got_q.size() <= q0 || got_q[q0] !== 8'h24) begin
            errors++;
            $display("FAIL single_char: got %h want 24", char_o);
        end
        checks++;
        if (fcnt !== f0 || ocnt !== o0) begin
            errors++;
            $display("FAIL single_errs: got f=%0d o=%0d want none", fcnt - f0, ocnt - o0);
        end
        lat = write_cyc - fall_cyc;
        checks++;
        if (lat < 154 || lat > 156) begin
            errors++;
            $display("FAIL single_latency: got %0d want 154..156", lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] msg[5] = '{8'h47, 8'h50, 8'h48, 8'h44, 8'h54};
        int w0 = wcnt;
        int q0 = got_q.size();
        for (int i = 0; i < 5; i++) send_byte(msg[i], 0, 0);
        tick(4);
        checks++;
        if (wcnt - w0 !== 5) begin
            errors++;
            $display("FAIL b2b_count: got %0d writes want 5", wcnt - w0);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_q.size() <= q0 + i || got_q[q0 + i] !== msg[i]) begin
                errors++;
                $display("FAIL b2b_char%0d: got %h want %h", i,
                         (got_q.size() > q0 + i) ? got_q[q0 + i] : 8'hxx, msg[i]);
            end
        end
    endtask

    task automatic test_glitch;
        int w0 = wcnt;
        int f0 = fcnt;
        int o0 = ocnt;
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(30);
        checks++;
        if (wcnt !== w0 || fcnt !== f0 || ocnt !== o0) begin
            errors++;
            $display("FAIL glitch_quiet: got w=%0d f=%0d o=%0d want 0 0 0",
                     wcnt - w0, fcnt - f0, ocnt - o0);
        end
        send_byte(8'h2A, 0, 0);
        tick(4);
        checks++;
        if (wcnt - w0 !== 1 || char_o !== 8'h2A) begin
            errors++;
            $display("FAIL glitch_next: got %0d writes char %h want 1 2a", wcnt - w0, char_o);
        end
    endtask

    task automatic test_frame_err;
        int w0 = wcnt;
        int f0 = fcnt;
        send_byte(8'h0D, 0, 40);
        tick(10);
        checks++;
        if (fcnt - f0 !== 1) begin
            errors++;
            $display("FAIL frame_pulse: got %0d want 1", fcnt - f0);
        end
        checks++;
        if (wcnt !== w0) begin
            errors++;
            $display("FAIL frame_nowrite: got %0d writes want 0", wcnt - w0);
        end
        send_byte(8'h2C, 0, 0);
        tick(4);
        checks++;
        if (wcnt - w0 !== 1 || char_o !== 8'h2C) begin
            errors++;
            $display("FAIL frame_next: got %0d writes char %h want 1 2c", wcnt - w0, char_o);
        end
    endtask

    task automatic test_overrun;
        int w0 = wcnt;
        int o0 = ocnt;
        send_byte(8'h31, 1, 0);
        tick(4);
        checks++;
        if (ocnt - o0 !== 1) begin
            errors++;
            $display("FAIL overrun_pulse: got %0d want 1", ocnt - o0);
        end
        checks++;
        if (wcnt !== w0) begin
            errors++;
            $display("FAIL overrun_nowrite: got %0d writes want 0", wcnt - w0);
        end
        checks++;
        if (char_o !== 8'h2C) begin
            errors++;
            $display("FAIL overrun_hold: got %h want 2c", char_o);
        end
        // Full during the data bits only must not block the write.
        send_byte(8'h52, 2, 0);
        tick(4);
        checks++;
        if (wcnt - w0 !== 1 || char_o !== 8'h52 || ocnt - o0 !== 1) begin
            errors++;
            $display("FAIL full_ignored: got w=%0d char %h o=%0d want 1 52 1",
                     wcnt - w0, char_o, ocnt - o0);
        end
    endtask

    task automatic test_reset_midframe;
        int w0;
        rx = 1'b0;
        tick(Cpb);
        rx = 1'b1;
        tick(4 * Cpb);
        rst_n = 1'b0;
        tick(3);
        checks++;
        if (char_o !== 8'h00) begin
            errors++;
            $display("FAIL midrst_char: got %h want 00", char_o);
        end
        w0    = wcnt;
        rst_n = 1'b1;
        tick(20);
        send_byte(8'h35, 0, 0);
        tick(20);
        checks++;
        if (wcnt - w0 !== 1 || char_o !== 8'h35) begin
            errors++;
            $display("FAIL midrst_next: got %0d writes char %h want 1 35", wcnt - w0, char_o);
        end
    endtask

    task automatic test_pulse_shape;
        checks++;
        if (excl_err !== 0) begin
            errors++;
            $display("FAIL pulse_exclusive: got %0d overlaps want 0", excl_err);
        end
        checks++;
        if (long_err !== 0) begin
            errors++;
            $display("FAIL pulse_width: got %0d back-to-back pulse cycles want 0", long_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_midframe();
        test_pulse_shape();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
